// File: rtl/and_arbiter.sv
// Round-robin arbiter in front of a shared bitwise-AND unit.
// Registered response port with backpressure and a saturating op counter.
module and_arbiter #(
  parameter int N     = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [N-1:0]      resp_data,
  output logic [ID_W-1:0]   resp_id,
  input  logic              resp_ready,
  output logic [CNT_W-1:0]  op_count
);

  logic              vld_q, vld_d;
  logic [N-1:0]      data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic              accept_ok;
  logic              accept;
  logic [NREQ-1:0]   onehot;
  logic [N-1:0]      sel_a;
  logic [N-1:0]      sel_b;

  // Search starts at the pointer and wraps past the top requester.
  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = ID_W'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept_ok = !vld_q || resp_ready;
  assign accept    = accept_ok && found && !rst;

  always_comb begin
    onehot      = '0;
    onehot[win] = 1'b1;
  end

  assign req_ready = accept ? onehot : '0;

  assign sel_a = req_a[win*N +: N];
  assign sel_b = req_b[win*N +: N];

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (accept) begin
      vld_d  = 1'b1;
      data_d = sel_a & sel_b;
      id_d   = win;
      ptr_d  = (win == ID_W'(NREQ-1)) ? '0 : win + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (resp_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign resp_valid = vld_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_and_arbiter.sv
// Directed bench for and_arbiter: grant order, backpressure,
// reset behaviour and counter saturation (second instance, CNT_W=2).
module tb_and_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b1111;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready = 1'b1;
  logic [7:0]  op_count;

  logic [3:0]  s_req_ready;
  logic        s_resp_valid;
  logic [7:0]  s_resp_data;
  logic [1:0]  s_resp_id;
  logic [1:0]  s_op_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  logic [7:0] exp_and [4];

  always #5 clk = ~clk;

  and_arbiter #(.N(8), .NREQ(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready), .op_count(op_count)
  );

  and_arbiter #(.N(8), .NREQ(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(s_req_ready),
    .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .resp_id(s_resp_id),
    .resp_ready(resp_ready), .op_count(s_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
    chk({tag, "_satcnt"}, 32'(s_op_count),
        32'(exp_cnt > 3 ? 3 : exp_cnt));
  endtask

  task automatic chk_resp(input string tag, input int id);
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    chk({tag, "_data"}, 32'(resp_data), 32'(exp_and[id]));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // r0: FF&5A=5A, r1: 0F&33=03, r2: F0&3C=30, r3: AA&CC=88
    req_a = {8'hAA, 8'hF0, 8'h0F, 8'hFF};
    req_b = {8'hCC, 8'h3C, 8'h33, 8'h5A};
    exp_and[0] = 8'h5A;
    exp_and[1] = 8'h03;
    exp_and[2] = 8'h30;
    exp_and[3] = 8'h88;

    // Reset with all requests pending
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_vld", 32'(resp_valid), 32'h0);
    chk("rst_data", 32'(resp_data), 32'h0);
    chk("rst_id", 32'(resp_id), 32'h0);
    chk_cnt("rst");
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);

    // Single request on requester 2
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    exp_cnt = 1;
    chk_resp("single", 2);
    chk_cnt("single");

    // Wrap-around: grant 3, then 1001 gives 0 then 3
    req_valid = 4'b1000;
    #1;
    chk("wrap3_ready", 32'(req_ready), 32'b1000);
    tick();
    exp_cnt = 2;
    chk_resp("wrap3", 3);
    req_valid = 4'b1001;
    #1;
    chk("wrap0_ready", 32'(req_ready), 32'b0001);
    tick();
    exp_cnt = 3;
    chk_resp("wrap0", 0);
    chk_cnt("wrap0");
    req_valid = 4'b1000;
    #1;
    chk("wrap3b_ready", 32'(req_ready), 32'b1000);
    tick();
    exp_cnt = 4;
    chk_resp("wrap3b", 3);
    chk_cnt("wrap3b");

    // Fairness: all requesting, one result per cycle
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("fair%0d_ready", i), 32'(req_ready),
          32'(4'b0001 << (i % 4)));
      tick();
      exp_cnt++;
      chk_resp($sformatf("fair%0d", i), i % 4);
    end
    chk_cnt("fair");

    // Backpressure: result for r3 pending, stall 3 cycles
    resp_ready = 1'b0;
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_ready", i), 32'(req_ready), 32'h0);
      chk_resp($sformatf("stall%0d", i), 3);
      tick();
    end
    chk_cnt("stall");
    resp_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(req_ready), 32'b0001);
    tick();
    exp_cnt++;
    chk_resp("unstall", 0);
    req_valid = 4'b0010;
    #1;
    chk("unstall1_ready", 32'(req_ready), 32'b0010);
    tick();
    exp_cnt++;
    chk_resp("unstall1", 1);
    chk_cnt("unstall1");

    // Drain with no new request: valid drops, data/id hold
    req_valid = 4'b0000;
    tick();
    chk("drain_vld", 32'(resp_valid), 32'h0);
    chk("drain_id", 32'(resp_id), 32'd1);
    chk("drain_data", 32'(resp_data), 32'h03);
    tick();
    chk("idle_vld", 32'(resp_valid), 32'h0);
    chk_cnt("idle");

    // Reset mid-operation while a response is pending
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'b0100);
    tick();
    exp_cnt++;
    chk_resp("pre_rst", 2);
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk("midrst_vld", 32'(resp_valid), 32'h0);
    chk("midrst_data", 32'(resp_data), 32'h0);
    chk_cnt("midrst");
    req_valid = 4'b1111;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("postrst_ready", 32'(req_ready), 32'b0001);
    tick();
    exp_cnt++;
    chk_resp("postrst", 0);

    // Saturation: 4 more accepts, narrow counter stops at 3
    for (int i = 1; i < 5; i++) begin
      tick();
      exp_cnt++;
      chk_resp($sformatf("sat%0d", i), i % 4);
    end
    chk("sat_narrow", 32'(s_op_count), 32'd3);
    chk_cnt("sat");
    req_valid = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
